// File: rtl/seq_div_if.sv
// Handshake and operand/result bundle for the sequential divider.
// Latency: none, wires only.
// Backpressure: start is only honoured while ready is high.
interface seq_div_if #(
  parameter int DW = 4,
  parameter int VW = 2
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, dbz
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/seq_div.sv
// Iterative restoring divider: unsigned DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Latency: done in the cycle after the DW-th edge past accept (1st edge for a zero divisor).
// Backpressure: ready is low while busy; start in the done cycle is accepted back-to-back.
module seq_div #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input logic      clk,
  input logic      rst_n,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(DW);
  localparam int PW = VW + 1;

  typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DW-1:0] shreg_q, shreg_d;
  // One bit wider than the divisor so the trial compare cannot overflow.
  logic [PW-1:0] part_q, part_d;
  logic [VW-1:0] dvsr_q, dvsr_d;

  logic [PW:0]   trial_w;
  logic          qbit_w;

  // Next-state logic: operand capture, one restoring step per CALC cycle, result latch on the last step.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    part_d  = part_q;
    dvsr_d  = dvsr_q;
    trial_w = {part_q, shreg_q[DW-1]};
    qbit_w  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ready_d = 1'b0;
          if (bus.divisor != '0) begin
            state_d = CALC;
            shreg_d = bus.dividend;
            part_d  = '0;
            cnt_d   = CW'(DW - 1);
            dvsr_d  = bus.divisor;
          end else begin
            state_d = ZERO;
          end
        end
      end

      CALC: begin
        if (trial_w >= {2'b00, dvsr_q}) begin
          part_d = PW'(trial_w - {2'b00, dvsr_q});
          qbit_w = 1'b1;
        end else begin
          part_d = trial_w[PW-1:0];
        end
        shreg_d = {shreg_q[DW-2:0], qbit_w};
        if (cnt_q == '0) begin
          quot_d  = shreg_d;
          rem_d   = part_d[VW-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ZERO: begin
        quot_d  = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight division without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      part_q  <= '0;
      dvsr_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      part_q  <= part_d;
      dvsr_q  <= dvsr_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div (DW=4, VW=2): directed, randomized and exhaustive back-to-back divisions.
// Expected results come from plain integer division; latency from the operand rules.
// Inputs are driven and outputs sampled on the falling edge.
module tb_seq_div;

  localparam int DW = 4;
  localparam int VW = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_div_if #(.DW(DW), .VW(VW)) bus ();

  seq_div #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer division, all-ones quotient and dbz for a zero divisor.
  function automatic void model(input int a, input int b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = '0; z = 1'b1; lat = 1;
    end else begin
      q = DW'(a / b); r = VW'(a % b); z = 1'b0; lat = DW;
    end
  endfunction

  // Issue one division from a falling edge with ready high; report latency and ready after accept.
  task automatic do_div(input int a, input int b, output int lat, output logic rdy_after);
    bus.start    = 1'b1;
    bus.dividend = DW'(a);
    bus.divisor  = VW'(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    rdy_after    = bus.ready;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.dbz} !== {1'b1, 1'b0, 4'h0, 2'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b done=%b q=%h r=%h dbz=%b want 1 0 0 0 0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b done=%b want 1 0", bus.ready, bus.done);
    end
  endtask

  task automatic test_basic;
    int ta[5] = '{9, 15, 2, 13, 6};
    int tb[5] = '{2, 3, 3, 0, 3};
    logic [DW-1:0] eq; logic [VW-1:0] er; logic ez; int el;
    int lat; logic rdy;
    logic [DW-1:0] held_q;
    for (int i = 0; i < 5; i++) begin
      model(ta[i], tb[i], eq, er, ez, el);
      do_div(ta[i], tb[i], lat, rdy);
      checks++;
      if (rdy !== 1'b0) begin
        errors++; $display("FAIL basic_ready_drop %0d/%0d got %b want 0", ta[i], tb[i], rdy);
      end
      checks++;
      if (lat != el) begin
        errors++; $display("FAIL basic_latency %0d/%0d got %0d want %0d", ta[i], tb[i], lat, el);
      end
      checks++;
      if ({bus.quotient, bus.remainder, bus.dbz, bus.ready} !== {eq, er, ez, 1'b1}) begin
        errors++;
        $display("FAIL basic_result %0d/%0d got q=%h r=%h dbz=%b rdy=%b want q=%h r=%h dbz=%b rdy=1",
                 ta[i], tb[i], bus.quotient, bus.remainder, bus.dbz, bus.ready, eq, er, ez);
      end
      held_q = bus.quotient;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.quotient !== eq || held_q !== eq) begin
        errors++;
        $display("FAIL basic_pulse_hold %0d/%0d got done=%b q=%h want done=0 q=%h",
                 ta[i], tb[i], bus.done, bus.quotient, eq);
      end
    end
  endtask

  task automatic test_ignore_start;
    int n_done = 0; int lat = -1;
    logic [DW-1:0] q_seen = '0; logic [VW-1:0] r_seen = '0;
    bus.start = 1'b1; bus.dividend = 4'h9; bus.divisor = 2'b10;
    @(negedge clk);
    bus.dividend = 4'hF; bus.divisor = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) begin n_done++; lat = 1; end
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (lat < 0) begin lat = k; q_seen = bus.quotient; r_seen = bus.remainder; end
      end
    end
    checks++;
    if (n_done != 1 || lat != DW) begin
      errors++; $display("FAIL ignore_start_done got count=%0d lat=%0d want 1 %0d", n_done, lat, DW);
    end
    checks++;
    if (q_seen !== 4'h4 || r_seen !== 2'b01) begin
      errors++; $display("FAIL ignore_start_result got q=%h r=%h want q=4 r=1", q_seen, r_seen);
    end
  endtask

  task automatic test_reset_mid;
    int n_done = 0; int lat; logic rdy;
    bus.start = 1'b1; bus.dividend = 4'h6; bus.divisor = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.dbz} !== {1'b1, 1'b0, 4'h0, 2'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_outputs got rdy=%b done=%b q=%h r=%h dbz=%b want 1 0 0 0 0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL reset_mid_no_done got %0d pulses want 0", n_done);
    end
    do_div(6, 2, lat, rdy);
    checks++;
    if (lat != DW || bus.quotient !== 4'h3 || bus.remainder !== 2'b00 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next got lat=%0d q=%h r=%h dbz=%b want %0d 3 0 0",
               lat, bus.quotient, bus.remainder, bus.dbz, DW);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [DW-1:0] eq; logic [VW-1:0] er; logic ez; int el;
    int a, b, lat; logic rdy;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(15));
      b = int'($urandom_range(3));
      model(a, b, eq, er, ez, el);
      do_div(a, b, lat, rdy);
      checks++;
      if (lat != el || rdy !== 1'b0 || {bus.quotient, bus.remainder, bus.dbz} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL random %0d/%0d got lat=%0d rdy=%b q=%h r=%h dbz=%b want lat=%0d rdy=0 q=%h r=%h dbz=%b",
                 a, b, lat, rdy, bus.quotient, bus.remainder, bus.dbz, el, eq, er, ez);
      end
      if ($urandom_range(1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] eq; logic [VW-1:0] er; logic ez; int el;
    int n_done = 0; int last_c = 0; int a, b;
    bus.start = 1'b1; bus.dividend = 4'h0; bus.divisor = 2'b00;
    for (int c = 1; c <= 600 && n_done < 64; c++) begin
      @(negedge clk);
      if (bus.done) begin
        a = n_done >> 2;
        b = n_done & 3;
        model(a, b, eq, er, ez, el);
        checks++;
        if ({bus.quotient, bus.remainder, bus.dbz, bus.ready} !== {eq, er, ez, 1'b1}) begin
          errors++;
          $display("FAIL b2b_result %0d/%0d got q=%h r=%h dbz=%b rdy=%b want q=%h r=%h dbz=%b rdy=1",
                   a, b, bus.quotient, bus.remainder, bus.dbz, bus.ready, eq, er, ez);
        end
        if (b != 0) begin
          checks++;
          if (int'(bus.quotient) * b + int'(bus.remainder) != a || int'(bus.remainder) >= b) begin
            errors++;
            $display("FAIL b2b_identity %0d/%0d got q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
          end
        end
        checks++;
        if (c - last_c != el + 1) begin
          errors++; $display("FAIL b2b_spacing %0d/%0d got %0d want %0d", a, b, c - last_c, el + 1);
        end
        last_c = c;
        n_done++;
        if (n_done < 64) begin
          bus.dividend = DW'(n_done >> 2);
          bus.divisor  = VW'(n_done & 3);
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (n_done != 64) begin
      errors++; $display("FAIL b2b_count got %0d want 64", n_done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Iterative restoring divider; the inverse of the team's small combinational multiplier.
- Takes an unsigned DW-bit dividend and a VW-bit divisor, and returns quotient and remainder after a fixed number of cycles.
- Retires one quotient bit per clock. Uses a ready/start/done handshake so upstream control logic can issue back-to-back divisions.

Parameters:
- DW, 4, dividend and quotient width (>=2)
- VW, 2, divisor and remainder width (>=1, VW <= DW)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- dividend  in  DW  unsigned dividend; captured on the accepting edge
- divisor  in  VW  unsigned divisor; captured on the accepting edge
- ready  out  1  high when a new start will be accepted
- done  out  1  one-cycle pulse: result valid
- quotient  out  DW  result quotient
- remainder  out  VW  result remainder
- dbz  out  1  divide-by-zero flag, valid with done

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 immediately clears state to IDLE.
  - Outputs under reset: ready=1, done=0, quotient=0, remainder=0, dbz=0, bit counter=0.
  - Applies mid-operation as well: the in-flight division is discarded with no done pulse.
- States: IDLE, CALC, ZERO.
- IDLE:
  - ready=1.
  - start=1 with divisor!=0 -> CALC. Load the shift register with dividend, clear the partial remainder (VW+1 bits), set counter=DW-1.
  - start=1 with divisor==0 -> ZERO.
- CALC:
  - ready=0; start is ignored, and input changes have no effect.
  - Each edge: shift the partial remainder left and bring in the next dividend MSB. If partial >= divisor, subtract and shift in quotient bit 1; otherwise shift in 0.
  - counter=0 on an edge -> latch quotient/remainder, set dbz=0, go to IDLE with done=1.
- ZERO:
  - Single edge. Set quotient = all ones, remainder=0, dbz=1, go to IDLE with done=1.
- Latency:
  - Normal: done is high in the cycle following the DW-th rising edge after the accepting edge.
  - Divide by zero: done follows the 1st rising edge after the accepting edge.
- done:
  - High for exactly one cycle, and coincides with ready=1.
  - start in the done cycle is accepted (back-to-back throughput = DW+1 cycles per divide).
- Result hold:
  - quotient, remainder and dbz change only on the edge that raises done.
  - They hold their values until the next completion or reset.
- Arithmetic:
  - Requirement: dividend = quotient*divisor + remainder, with remainder < divisor.
  - Partial remainder is VW+1 bits wide so the compare never overflows.

Test Plan:
- DW=4, VW=2. start with dividend=4'b1001, divisor=2'b10 -> ready drops next cycle; done after 4 edges; quotient=4'b0100, remainder=2'b01, dbz=0.
- dividend=4'hF, divisor=2'b11 -> quotient=4'b0101, remainder=0. dividend=4'h2, divisor=2'b11 -> quotient=0, remainder=2'b10.
- dividend=4'hD, divisor=0 -> done one edge after accept; quotient=4'hF, remainder=0, dbz=1. Next divide 4'h6/2'b11 -> dbz=0, quotient=2, remainder=0.
- Pulse start with new operands during CALC -> ignored; the result matches the original operands; exactly one done pulse.
- Deassert rst_n in the 2nd CALC cycle -> ready=1, done=0, quotient=0, remainder=0, dbz=0 immediately, with no later done. Then 4'h6/2'b10 -> quotient=3, remainder=0.
- Exhaustive back-to-back run: all 64 operand pairs with start held high, each issued in the prior done cycle. Check quotient*divisor+remainder == dividend, remainder < divisor, and one done every 5 cycles (2 cycles for divisor=0).
